// File: rtl/sync_req_arbiter.sv
// Synchronizes NUM_REQ asynchronous request lines, holds their rising edges as pending
// requests and serves them round-robin on one shared resource with a done/timeout handshake.
module sync_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter bit          SYNC_IDLE      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         async_req,
  input  logic                       res_done,
  input  logic                       clr_overrun,
  output logic                       res_start,
  output logic [$clog2(NUM_REQ)-1:0] res_sel,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       active,
  output logic [NUM_REQ-1:0]         overrun,
  output logic                       timeout
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] IDLE_VEC = {NUM_REQ{SYNC_IDLE}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  logic [NUM_REQ-1:0] meta_q, sync_q, prev_q;
  logic [NUM_REQ-1:0] edge_c;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] overrun_q, overrun_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               active_q, active_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pend_clr_c;
  logic               pick_found_c;
  logic [SEL_W-1:0]   pick_idx_c;
  logic [SEL_W-1:0]   cand_c;

  // Two-flop synchronizer plus edge-history flop per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= IDLE_VEC;
      sync_q <= IDLE_VEC;
      prev_q <= IDLE_VEC;
    end else begin
      meta_q <= async_req;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_c = sync_q & ~prev_q;

  // Round-robin search starting just after the last served channel
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_c = SEL_W'((32'(last_q) + k) % NUM_REQ);
      if (!pick_found_c && pending_q[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_clr_c = '0;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    active_d   = active_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          state_d                = ST_START;
          sel_d                  = pick_idx_c;
          grant_d                = NUM_REQ'(1) << pick_idx_c;
          pend_clr_c[pick_idx_c] = 1'b1;
          start_d                = 1'b1;
          active_d               = 1'b1;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // res_done wins over an expiring counter in the same cycle
        if (res_done || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          active_d  = 1'b0;
          last_d    = sel_q;
          timeout_d = !res_done;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        active_d = 1'b0;
      end
    endcase

    // A new edge always wins over the grant-time clear / overrun clear
    pending_d = (pending_q & ~pend_clr_c) | edge_c;
    overrun_d = (clr_overrun ? '0 : overrun_q) | (edge_c & pending_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  assign res_start = start_q;
  assign res_sel   = sel_q;
  assign grant     = grant_q;
  assign active    = active_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Bench for sync_req_arbiter: directed scenarios plus random traffic, every cycle checked
// against a cycle-level reference model of request arrival, job lifetime and rotation.
module tb_sync_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] async_req;
  logic         res_done;
  logic         clr_overrun;
  logic         res_start;
  logic [1:0]   res_sel;
  logic [N-1:0] grant;
  logic         active;
  logic [N-1:0] overrun;
  logic         timeout;

  int checks = 0;
  int fails  = 0;

  sync_req_arbiter #(
    .NUM_REQ       (N),
    .SYNC_IDLE     (1'b0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .async_req  (async_req),
    .res_done   (res_done),
    .clr_overrun(clr_overrun),
    .res_start  (res_start),
    .res_sel    (res_sel),
    .grant      (grant),
    .active     (active),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: input history, pending set, and a job described by owner + age
  logic [N-1:0] h1, h2, h3;
  logic [N-1:0] m_pend, m_ovr;
  bit           m_busy, m_to;
  int           m_age, m_owner, m_last;

  task automatic m_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_ovr = '0;
    m_busy = 0; m_to = 0; m_age = 0; m_owner = 0; m_last = N - 1;
  endtask

  task automatic m_update();
    logic [N-1:0] ev, newovr;
    ev     = h2 & ~h3;
    newovr = ev & m_pend;
    m_to   = 0;
    if (m_busy) begin
      if (m_age == 0) m_age = 1;
      else if (res_done) begin m_busy = 0; m_last = m_owner; end
      else if (m_age == TO) begin m_busy = 0; m_last = m_owner; m_to = 1; end
      else m_age++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_pend[c]) begin
          m_busy = 1; m_age = 0; m_owner = c; m_pend[c] = 1'b0;
          break;
        end
      end
    end
    m_pend = m_pend | ev;
    m_ovr  = (clr_overrun ? '0 : m_ovr) | newovr;
    h3 = h2; h2 = h1; h1 = async_req;
  endtask

  function automatic logic [12:0] dut_vec();
    return {res_start, active, res_sel, grant, overrun, timeout};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [N-1:0] g;
    g = m_busy ? 4'(1 << m_owner) : 4'b0;
    return {logic'(m_busy && m_age == 0), logic'(m_busy), 2'(m_owner), g, m_ovr, logic'(m_to)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_update();
    #1;
  endtask

  task automatic do_reset();
    async_req = '0; res_done = 1'b0; clr_overrun = 1'b0; rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    async_req = '0; res_done = 1'b0; clr_overrun = 1'b0; rst = 1'b1;
    m_reset();
    #3;
    checks++;
    if (dut_vec() !== 13'b0) begin
      fails++; $display("FAIL reset_state dut=%b exp=%b", dut_vec(), 13'b0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_idle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int lat = 0;
    int starts = 0;
    do_reset();
    async_req[2] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL single_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (res_start) begin starts++; if (lat == 0) lat = c; end
      if (active) begin
        checks++;
        if (grant !== 4'b0100 || res_sel !== 2'd2) begin
          fails++; $display("FAIL single_grant grant=%b sel=%0d exp grant=0100 sel=2", grant, res_sel);
        end
      end
      res_done = (lat != 0 && c == lat + 2);
    end
    checks++;
    if (lat !== 4 || starts !== 1) begin
      fails++; $display("FAIL single_latency latency=%0d starts=%0d exp latency=4 starts=1", lat, starts);
    end
    checks++;
    if (grant !== 4'b0 || active !== 1'b0) begin
      fails++; $display("FAIL single_end grant=%b active=%b exp 0000/0", grant, active);
    end
    async_req = '0;
  endtask

  task automatic test_simul();
    int gq[$];
    int since = 100;
    do_reset();
    async_req = 4'b1011;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL simul_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (res_start) begin gq.push_back(int'(res_sel)); since = 0; end
      else since++;
      res_done = (since == 1);
    end
    checks++;
    if (gq.size() != 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 3) begin
      fails++; $display("FAIL simul_order got %0d grants %p exp 0,1,3", gq.size(), gq);
    end
    checks++;
    if (overrun !== 4'b0) begin
      fails++; $display("FAIL simul_overrun overrun=%b exp 0000", overrun);
    end
    async_req = '0; res_done = 1'b0;
  endtask

  task automatic test_rr();
    int gq[$];
    int rise = -1;
    bit ok = 1;
    do_reset();
    async_req = 4'b0011;
    for (int c = 1; c <= 80 && gq.size() < 6; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rr_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (rise >= 0) begin async_req[rise] = 1'b1; rise = -1; end
      if (res_start) begin
        gq.push_back(int'(res_sel));
        async_req[res_sel] = 1'b0;
        rise = int'(res_sel);
      end
      res_done = active;
    end
    for (int i = 0; i < gq.size(); i++) if (gq[i] != (i % 2)) ok = 0;
    checks++;
    if (gq.size() != 6 || !ok) begin
      fails++; $display("FAIL rr_order got %p exp 0,1,0,1,0,1", gq);
    end
    async_req = '0; res_done = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_overrun();
    int since = 100;
    int ch1_jobs = 0;
    do_reset();
    async_req = 4'b0011;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL ovr_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (res_start) begin since = 0; if (res_sel == 2'd1) ch1_jobs++; end
      else since++;
      async_req[1] = (c < 3) || (c >= 6 && c < 9);
      res_done = (since == 6);
    end
    checks++;
    if (overrun !== 4'b0010 || ch1_jobs != 1) begin
      fails++; $display("FAIL ovr_set overrun=%b ch1_jobs=%0d exp 0010 and 1", overrun, ch1_jobs);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 4'b0) begin
      fails++; $display("FAIL ovr_clear overrun=%b exp 0000", overrun);
    end
    async_req = '0; res_done = 1'b0;
  endtask

  task automatic test_timeout();
    int gq[$];
    int s2 = -1;
    int to_c = -1;
    int n_to = 0;
    do_reset();
    async_req = 4'b1100;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL to_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (res_start) begin gq.push_back(int'(res_sel)); if (res_sel == 2'd2) s2 = c; end
      if (timeout) begin
        n_to++; to_c = c;
        checks++;
        if (grant !== 4'b0) begin
          fails++; $display("FAIL to_grant_drop grant=%b exp 0000", grant);
        end
      end
      res_done = active && !res_start && (res_sel == 2'd3);
    end
    checks++;
    if (s2 < 0 || to_c - s2 != TO + 1 || n_to != 1) begin
      fails++; $display("FAIL to_timing start=%0d timeout=%0d count=%0d exp distance %0d count 1", s2, to_c, n_to, TO + 1);
    end
    checks++;
    if (gq.size() != 2 || gq[0] != 2 || gq[1] != 3) begin
      fails++; $display("FAIL to_next got %p exp 2,3", gq);
    end
    async_req = '0; res_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    do_reset();
    async_req = 4'b0011;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rmid_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (active && !res_start) break;
    end
    checks++;
    if (active !== 1'b1 || grant !== 4'b0001) begin
      fails++; $display("FAIL rmid_pre active=%b grant=%b exp 1/0001", active, grant);
    end
    #2 rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({grant, active, res_start} !== 6'b0) begin
      fails++; $display("FAIL rmid_async grant=%b active=%b start=%b exp all 0", grant, active, res_start);
    end
    async_req = '0;
    repeat (2) step();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rmid_after t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      if (res_start) starts++;
    end
    checks++;
    if (starts != 0) begin
      fails++; $display("FAIL rmid_nostart starts=%0d exp 0", starts);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rand_cycle t=%0t dut=%b exp=%b", $time, dut_vec(), exp_vec());
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) async_req[i] = ~async_req[i];
      res_done    = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
    end
    async_req = '0; res_done = 1'b0; clr_overrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_rr();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
